adc_spi_arbiter: RTL and testbench

- Shares the single AD4630 SPI master between two requesters: the cyclic conversion-read path (SDR 4-lane data read, CPOL/CPHA 00) and the host register-config path (24-bit frames, CPOL/CPHA 01).
- Conversion reads always win. Config frames run only when enough cycles remain before the next conversion.
- Inserts a settle gap whenever the SPI mode changes, and guards every transfer with a timeout.
- Sits between the ADC sequencer / PS register bank and the SPI master.

---
 rtl/adc_spi_arbiter_if.sv | 37 +++
 rtl/adc_spi_arbiter.sv | 156 +++++++++++++++
 tb/tb_adc_spi_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_spi_arbiter_if.sv
// Bus between the AD4630 SPI arbiter and its surroundings.
// The arbiter uses the slave view; the sequencer, host and SPI master together use the master view.
interface adc_spi_arbiter_if;
  logic        i_rd_req;
  logic        o_rd_done;
  logic        i_cfg_req;
  logic [23:0] i_cfg_wdata;
  logic        o_cfg_done;
  logic [23:0] o_cfg_rdata;
  logic        o_cfg_busy;
  logic [31:0] i_cyc_remain;
  logic        o_spi_start;
  logic        o_spi_mode;
  logic [23:0] o_spi_tx_data;
  logic        i_spi_done;
  logic [23:0] i_spi_rx_data;
  logic        i_err_clr;
  logic        o_err_timeout;
  logic        o_err_overrun;
  logic [2:0]  o_state;

  modport slave (
    input  i_rd_req, i_cfg_req, i_cfg_wdata, i_cyc_remain,
    input  i_spi_done, i_spi_rx_data, i_err_clr,
    output o_rd_done, o_cfg_done, o_cfg_rdata, o_cfg_busy,
    output o_spi_start, o_spi_mode, o_spi_tx_data,
    output o_err_timeout, o_err_overrun, o_state
  );

  modport master (
    output i_rd_req, i_cfg_req, i_cfg_wdata, i_cyc_remain,
    output i_spi_done, i_spi_rx_data, i_err_clr,
    input  o_rd_done, o_cfg_done, o_cfg_rdata, o_cfg_busy,
    input  o_spi_start, o_spi_mode, o_spi_tx_data,
    input  o_err_timeout, o_err_overrun, o_state
  );
endinterface

// File: rtl/adc_spi_arbiter.sv
// Shares one AD4630 SPI master between conversion reads (always first) and host config frames,
// with a settle gap on mode changes and a watchdog on every transfer.
module adc_spi_arbiter #(
  parameter int MODE_SETTLE = 4,
  parameter int CFG_GUARD   = 60,
  parameter int SPI_TIMEOUT = 1000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  adc_spi_arbiter_if.slave bus
);
  localparam int CNT_MAX = (SPI_TIMEOUT > MODE_SETTLE) ? SPI_TIMEOUT : MODE_SETTLE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t            state_reg, state_next;
  logic              rd_pend_reg, rd_pend_next;
  logic              cfg_pend_reg, cfg_pend_next;
  logic [23:0]       cfg_word_reg, cfg_word_next;
  logic [23:0]       cfg_rdata_reg, cfg_rdata_next;
  logic              sel_cfg_reg, sel_cfg_next;
  logic              spi_mode_reg, spi_mode_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              err_timeout_reg, err_timeout_next;
  logic              err_overrun_reg, err_overrun_next;

  logic grant_rd, grant_cfg, cfg_busy, read_active, timeout_hit, settle_last;

  assign grant_rd    = (state_reg == IDLE) && rd_pend_reg;
  assign grant_cfg   = (state_reg == IDLE) && !rd_pend_reg && cfg_pend_reg &&
                       (bus.i_cyc_remain >= 32'(CFG_GUARD));
  assign cfg_busy    = cfg_pend_reg || (sel_cfg_reg && (state_reg != IDLE));
  assign read_active = !sel_cfg_reg &&
                       ((state_reg == SETTLE) || (state_reg == START) || (state_reg == WAIT));
  assign settle_last = (cnt_reg == CNT_W'(MODE_SETTLE - 1));
  assign timeout_hit = (state_reg == WAIT) && !bus.i_spi_done &&
                       (cnt_reg == CNT_W'(SPI_TIMEOUT - 1));

  // State register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; done has priority over the watchdog terminal count
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant_rd || grant_cfg)
          state_next = (grant_cfg != spi_mode_reg) ? SETTLE : START;
      end
      SETTLE:  if (settle_last) state_next = START;
      START:   state_next = WAIT;
      WAIT: begin
        if (bus.i_spi_done)   state_next = DONE;
        else if (timeout_hit) state_next = IDLE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    bus.o_spi_start   = (state_reg == START);
    bus.o_rd_done     = (state_reg == DONE) && !sel_cfg_reg;
    bus.o_cfg_done    = (state_reg == DONE) && sel_cfg_reg;
    bus.o_spi_tx_data = (sel_cfg_reg && (state_reg != IDLE)) ? cfg_word_reg : 24'd0;
  end

  assign bus.o_state       = state_reg;
  assign bus.o_spi_mode    = spi_mode_reg;
  assign bus.o_cfg_busy    = cfg_busy;
  assign bus.o_cfg_rdata   = cfg_rdata_reg;
  assign bus.o_err_timeout = err_timeout_reg;
  assign bus.o_err_overrun = err_overrun_reg;

  always_comb begin
    rd_pend_next     = rd_pend_reg;
    cfg_pend_next    = cfg_pend_reg;
    cfg_word_next    = cfg_word_reg;
    cfg_rdata_next   = cfg_rdata_reg;
    sel_cfg_next     = sel_cfg_reg;
    spi_mode_next    = spi_mode_reg;
    cnt_next         = cnt_reg;
    err_timeout_next = err_timeout_reg;
    err_overrun_next = err_overrun_reg;

    if (grant_rd || grant_cfg) begin
      sel_cfg_next  = grant_cfg;
      spi_mode_next = grant_cfg;
      cnt_next      = '0;
    end
    if (grant_rd)  rd_pend_next  = 1'b0;
    if (grant_cfg) cfg_pend_next = 1'b0;

    // A read request on top of a pending or running read is merged, never queued twice
    if (bus.i_rd_req && !rd_pend_reg && !read_active) rd_pend_next = 1'b1;
    if (bus.i_cfg_req && !cfg_busy) begin
      cfg_pend_next = 1'b1;
      cfg_word_next = bus.i_cfg_wdata;
    end

    case (state_reg)
      SETTLE:  if (!settle_last) cnt_next = cnt_reg + 1'b1;
      START:   cnt_next = '0;
      WAIT: begin
        if (bus.i_spi_done) begin
          if (sel_cfg_reg) cfg_rdata_next = bus.i_spi_rx_data;
        end else if (!timeout_hit) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: ;
    endcase

    if (bus.i_err_clr) begin
      err_timeout_next = 1'b0;
      err_overrun_next = 1'b0;
    end
    if (timeout_hit) err_timeout_next = 1'b1;
    if (bus.i_rd_req && (rd_pend_reg || read_active)) err_overrun_next = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rd_pend_reg     <= 1'b0;
      cfg_pend_reg    <= 1'b0;
      cfg_word_reg    <= 24'd0;
      cfg_rdata_reg   <= 24'd0;
      sel_cfg_reg     <= 1'b0;
      spi_mode_reg    <= 1'b0;
      cnt_reg         <= '0;
      err_timeout_reg <= 1'b0;
      err_overrun_reg <= 1'b0;
    end else begin
      rd_pend_reg     <= rd_pend_next;
      cfg_pend_reg    <= cfg_pend_next;
      cfg_word_reg    <= cfg_word_next;
      cfg_rdata_reg   <= cfg_rdata_next;
      sel_cfg_reg     <= sel_cfg_next;
      spi_mode_reg    <= spi_mode_next;
      cnt_reg         <= cnt_next;
      err_timeout_reg <= err_timeout_next;
      err_overrun_reg <= err_overrun_next;
    end
  end
endmodule

// File: tb/tb_adc_spi_arbiter.sv
// Directed bench for adc_spi_arbiter: inputs change and outputs are sampled on the falling edge.
module tb_adc_spi_arbiter;
  logic i_clk;
  logic i_rst;
  int   checks;
  int   failures;

  adc_spi_arbiter_if bus ();

  adc_spi_arbiter #(
    .MODE_SETTLE(4),
    .CFG_GUARD(60),
    .SPI_TIMEOUT(1000)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus(bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
  endtask

  // Advance until o_spi_start is seen, counting SETTLE cycles on the way
  task automatic wait_start(output int settle, output logic seen);
    settle = 0;
    seen   = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (bus.o_spi_start) begin
        seen = 1'b1;
        break;
      end
      if (bus.o_state == 3'd1) settle++;
      tick();
    end
  endtask

  // Called in the START cycle; leaves the bench in the DONE cycle
  task automatic complete(input int gap, input logic [23:0] rx);
    repeat (gap) tick();
    bus.i_spi_rx_data = rx;
    bus.i_spi_done    = 1'b1;
    tick();
    bus.i_spi_done    = 1'b0;
  endtask

  task automatic count_starts(input int n, output int starts);
    starts = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (bus.o_spi_start) starts++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int   settle;
    logic seen;
    int   starts;
    logic done_seen;

    checks   = 0;
    failures = 0;
    i_rst               = 1'b0;
    bus.i_rd_req        = 1'b0;
    bus.i_cfg_req       = 1'b0;
    bus.i_cfg_wdata     = 24'd0;
    bus.i_cyc_remain    = 32'd0;
    bus.i_spi_done      = 1'b0;
    bus.i_spi_rx_data   = 24'd0;
    bus.i_err_clr       = 1'b0;

    repeat (3) tick();
    check("rst_state", 32'(bus.o_state), 0);
    check("rst_outs", {bus.o_rd_done, bus.o_cfg_done, bus.o_cfg_busy, bus.o_spi_start,
                       bus.o_spi_mode, bus.o_err_timeout, bus.o_err_overrun}, 0);
    check("rst_tx", 32'(bus.o_spi_tx_data), 0);
    check("rst_rdata", 32'(bus.o_cfg_rdata), 0);
    i_rst = 1'b1;
    tick();

    // Read in unchanged mode: start in the third cycle counting the request cycle
    bus.i_rd_req = 1'b1;
    tick();
    bus.i_rd_req = 1'b0;
    check("rd_no_early_start", 32'(bus.o_spi_start), 0);
    tick();
    check("rd_start", 32'(bus.o_spi_start), 1);
    check("rd_start_state", 32'(bus.o_state), 2);
    check("rd_mode", 32'(bus.o_spi_mode), 0);
    check("rd_tx", 32'(bus.o_spi_tx_data), 0);
    complete(20, 24'h123456);
    check("rd_done", 32'(bus.o_rd_done), 1);
    check("rd_done_state", 32'(bus.o_state), 4);
    tick();
    check("rd_done_width", 32'(bus.o_rd_done), 0);
    check("rd_back_idle", 32'(bus.o_state), 0);
    $display("txn read: done");

    // Config held back by the guard, then released
    bus.i_cyc_remain = 32'd40;
    bus.i_cfg_wdata  = 24'hBFFF00;
    bus.i_cfg_req    = 1'b1;
    tick();
    bus.i_cfg_req = 1'b0;
    check("cfg_busy_pend", 32'(bus.o_cfg_busy), 1);
    count_starts(6, starts);
    check("cfg_guard_nostart", 32'(starts), 0);
    check("cfg_guard_idle", 32'(bus.o_state), 0);
    bus.i_cyc_remain = 32'd80;
    wait_start(settle, seen);
    check("cfg_start_seen", 32'(seen), 1);
    check("cfg_settle_len", 32'(settle), 4);
    check("cfg_mode", 32'(bus.o_spi_mode), 1);
    check("cfg_tx", 32'(bus.o_spi_tx_data), 32'h00BFFF00);
    complete(1, 24'h002080);
    check("cfg_done", 32'(bus.o_cfg_done), 1);
    check("cfg_no_rd_done", 32'(bus.o_rd_done), 0);
    check("cfg_rdata", 32'(bus.o_cfg_rdata), 32'h00002080);
    check("cfg_busy_in_done", 32'(bus.o_cfg_busy), 1);
    bus.i_spi_rx_data = 24'd0;
    tick();
    check("cfg_busy_clear", 32'(bus.o_cfg_busy), 0);
    check("cfg_rdata_held", 32'(bus.o_cfg_rdata), 32'h00002080);
    $display("txn config: rdata=%06h", bus.o_cfg_rdata);

    // Simultaneous requests: read first, then config
    bus.i_cyc_remain = 32'd200;
    bus.i_cfg_wdata  = 24'h0A5A5A;
    bus.i_rd_req     = 1'b1;
    bus.i_cfg_req    = 1'b1;
    tick();
    bus.i_rd_req  = 1'b0;
    bus.i_cfg_req = 1'b0;
    wait_start(settle, seen);
    check("both_rd_start_seen", 32'(seen), 1);
    check("both_rd_settle", 32'(settle), 4);
    check("both_rd_mode", 32'(bus.o_spi_mode), 0);
    check("both_rd_tx", 32'(bus.o_spi_tx_data), 0);
    check("both_busy_rd", 32'(bus.o_cfg_busy), 1);
    complete(1, 24'h555555);
    check("both_rd_done", 32'(bus.o_rd_done), 1);
    check("both_busy_rd_done", 32'(bus.o_cfg_busy), 1);
    tick();
    wait_start(settle, seen);
    check("both_cfg_start_seen", 32'(seen), 1);
    check("both_cfg_settle", 32'(settle), 4);
    check("both_cfg_mode", 32'(bus.o_spi_mode), 1);
    check("both_cfg_tx", 32'(bus.o_spi_tx_data), 32'h000A5A5A);
    complete(1, 24'h00BEEF);
    check("both_cfg_done", 32'(bus.o_cfg_done), 1);
    check("both_cfg_rdata", 32'(bus.o_cfg_rdata), 32'h0000BEEF);
    tick();
    check("both_busy_end", 32'(bus.o_cfg_busy), 0);
    $display("txn read+config: done");

    // Timeout: WAIT lasts 1000 cycles, then abort without a done pulse
    bus.i_rd_req = 1'b1;
    tick();
    bus.i_rd_req = 1'b0;
    wait_start(settle, seen);
    check("to_start_seen", 32'(seen), 1);
    done_seen = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (bus.o_rd_done) done_seen = 1'b1;
    end
    check("to_last_wait", 32'(bus.o_state), 3);
    check("to_not_yet", 32'(bus.o_err_timeout), 0);
    tick();
    if (bus.o_rd_done) done_seen = 1'b1;
    check("to_idle", 32'(bus.o_state), 0);
    check("to_flag", 32'(bus.o_err_timeout), 1);
    check("to_no_done", 32'(done_seen), 0);
    bus.i_err_clr = 1'b1;
    tick();
    bus.i_err_clr = 1'b0;
    check("to_cleared", 32'(bus.o_err_timeout), 0);
    $display("txn read: timed out");

    // Overrun during WAIT, with a coincident clear that must lose
    bus.i_rd_req = 1'b1;
    tick();
    bus.i_rd_req = 1'b0;
    wait_start(settle, seen);
    check("ovr_start_seen", 32'(seen), 1);
    tick();
    bus.i_rd_req  = 1'b1;
    bus.i_err_clr = 1'b1;
    tick();
    bus.i_rd_req  = 1'b0;
    bus.i_err_clr = 1'b0;
    check("ovr_flag", 32'(bus.o_err_overrun), 1);
    complete(1, 24'd0);
    check("ovr_rd_done", 32'(bus.o_rd_done), 1);
    count_starts(10, starts);
    check("ovr_single_read", 32'(starts), 0);
    bus.i_err_clr = 1'b1;
    tick();
    bus.i_err_clr = 1'b0;
    check("ovr_cleared", 32'(bus.o_err_overrun), 0);
    $display("txn read: overrun merged");

    // Second config while busy is dropped
    bus.i_cfg_wdata = 24'hC0FFEE;
    bus.i_cfg_req   = 1'b1;
    tick();
    bus.i_cfg_wdata = 24'h001401;
    tick();
    bus.i_cfg_req = 1'b0;
    wait_start(settle, seen);
    check("drop_start_seen", 32'(seen), 1);
    check("drop_tx_first", 32'(bus.o_spi_tx_data), 32'h00C0FFEE);
    complete(1, 24'h00C0DE);
    check("drop_cfg_done", 32'(bus.o_cfg_done), 1);
    count_starts(10, starts);
    check("drop_no_second", 32'(starts), 0);
    check("drop_busy_end", 32'(bus.o_cfg_busy), 0);
    $display("txn config: second request dropped");

    // Asynchronous reset in the middle of a config WAIT, with a read pending
    bus.i_cfg_wdata = 24'hABCDEF;
    bus.i_cfg_req   = 1'b1;
    tick();
    bus.i_cfg_req = 1'b0;
    wait_start(settle, seen);
    check("rst_cfg_start_seen", 32'(seen), 1);
    bus.i_rd_req = 1'b1;
    tick();
    bus.i_rd_req = 1'b0;
    check("rst_pre_wait", 32'(bus.o_state), 3);
    check("rst_pre_mode", 32'(bus.o_spi_mode), 1);
    i_rst = 1'b0;
    #1;
    check("rst_async_state", 32'(bus.o_state), 0);
    check("rst_async_mode", 32'(bus.o_spi_mode), 0);
    check("rst_async_busy", 32'(bus.o_cfg_busy), 0);
    check("rst_async_tx", 32'(bus.o_spi_tx_data), 0);
    check("rst_async_rdata", 32'(bus.o_cfg_rdata), 0);
    tick();
    tick();
    i_rst = 1'b1;
    tick();
    bus.i_spi_done = 1'b1;
    tick();
    bus.i_spi_done = 1'b0;
    check("rst_late_done", {30'd0, bus.o_rd_done, bus.o_cfg_done}, 0);
    check("rst_late_state", 32'(bus.o_state), 0);
    count_starts(10, starts);
    check("rst_pending_lost", 32'(starts), 0);
    $display("txn reset: mid-transfer abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
